// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR transmitter: FSM states, frame size,
// default protocol timings in microseconds and small frame helpers.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEAD      = 3'd1,
    ST_SPACE     = 3'd2,
    ST_RSPACE    = 3'd3,
    ST_BIT_MARK  = 3'd4,
    ST_BIT_SPACE = 3'd5,
    ST_STOP      = 3'd6,
    ST_GAP       = 3'd7
  } nec_state_e;

  localparam int NEC_FRAME_BITS = 32;

  localparam int NEC_LEAD_US      = 9000;
  localparam int NEC_SPACE_US     = 4500;
  localparam int NEC_RPT_SPACE_US = 2250;
  localparam int NEC_BIT_US       = 560;
  localparam int NEC_ONE_US       = 1690;
  localparam int NEC_GAP_US       = 40000;
  localparam int NEC_CARRIER_HZ   = 38000;

  // States that drive a mark (line low) on the demodulated output.
  function automatic logic nec_is_mark(input nec_state_e st);
    logic mark;
    case (st)
      ST_LEAD, ST_BIT_MARK, ST_STOP: mark = 1'b1;
      default:                       mark = 1'b0;
    endcase
    return mark;
  endfunction

  // Frame word sent LSB first: addr, ~addr, data, ~data.
  function automatic logic [31:0] nec_frame(input logic [7:0] a, input logic [7:0] d);
    return {~d, d, ~a, a};
  endfunction

endpackage

// File: rtl/ir_us_tick.sv
// Microsecond strobe generator: divides clk by CLK_FREQ/1_000_000.
// A synchronous clr restarts the phase so a duration measured from clr
// is an exact multiple of the divider.
module ir_us_tick #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_FREQ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST     = PW'(DIV - 1);
  localparam logic          TICK_RST = (DIV == 1);

  logic [PW-1:0] cnt_r;
  logic [PW-1:0] cnt_nxt_s;
  logic          tick_r;

  // Next prescaler value: restart on clr, wrap at the last phase.
  always_comb begin
    cnt_nxt_s = {PW{1'b0}};
    if (clr) begin
      cnt_nxt_s = {PW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_nxt_s = {PW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + PW'(1);
    end
  end

  // Prescaler register and registered strobe (high while the counter sits on its last phase).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r  <= {PW{1'b0}};
      tick_r <= TICK_RST;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR frame generator. remote_out is the demodulated level (idle 1,
// mark 0). Optional macro IR_CARRIER_EN adds carrier_out, the modulated
// carrier gated by the marks.
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int LEAD_US      = NEC_LEAD_US,
  parameter int SPACE_US     = NEC_SPACE_US,
  parameter int RPT_SPACE_US = NEC_RPT_SPACE_US,
  parameter int BIT_US       = NEC_BIT_US,
  parameter int ONE_US       = NEC_ONE_US,
  parameter int GAP_US       = NEC_GAP_US
`ifdef IR_CARRIER_EN
  ,
  parameter int CARRIER_HZ   = NEC_CARRIER_HZ
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       send_en,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       remote_out
`ifdef IR_CARRIER_EN
  ,
  output logic       carrier_out
`endif
);

  // Counter must hold the longest state duration (gap or leader at defaults).
  localparam int US_MAX = (GAP_US > LEAD_US) ? GAP_US : LEAD_US;
  localparam int US_W   = $clog2(US_MAX + 1);

  localparam logic [US_W-1:0] LEAD_M1 = US_W'(LEAD_US - 1);
  localparam logic [US_W-1:0] SPC_M1  = US_W'(SPACE_US - 1);
  localparam logic [US_W-1:0] RPT_M1  = US_W'(RPT_SPACE_US - 1);
  localparam logic [US_W-1:0] BIT_M1  = US_W'(BIT_US - 1);
  localparam logic [US_W-1:0] ONE_M1  = US_W'(ONE_US - 1);
  localparam logic [US_W-1:0] GAP_M1  = US_W'(GAP_US - 1);
  localparam logic [4:0]      LAST_BIT = 5'(NEC_FRAME_BITS - 1);

  nec_state_e      state_r, state_nxt_s;
  logic [US_W-1:0] us_r;
  logic [US_W-1:0] dur_m1_s;
  logic [31:0]     shift_r;
  logic [4:0]      bit_idx_r;
  logic            rpt_r;
  logic            ent_r;
  logic            remote_out_r;
  logic            busy_r;
  logic            done_r;
  logic            tick_s;
  logic            accept_s;
  logic            end_s;
  logic            clr_s;

  assign accept_s = (state_r == ST_IDLE) && !busy_r && (send_en || repeat_req);
  assign end_s    = tick_s && (state_r != ST_IDLE) && (us_r == dur_m1_s);
  // Every state change restarts the microsecond phase and count.
  assign clr_s    = accept_s || end_s;

  ir_us_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Duration of the current state, minus one, in microseconds.
  always_comb begin
    dur_m1_s = {US_W{1'b0}};
    case (state_r)
      ST_LEAD:      dur_m1_s = LEAD_M1;
      ST_SPACE:     dur_m1_s = SPC_M1;
      ST_RSPACE:    dur_m1_s = RPT_M1;
      ST_BIT_MARK:  dur_m1_s = BIT_M1;
      ST_BIT_SPACE: dur_m1_s = shift_r[0] ? ONE_M1 : BIT_M1;
      ST_STOP:      dur_m1_s = BIT_M1;
      ST_GAP:       dur_m1_s = GAP_M1;
      default:      dur_m1_s = {US_W{1'b0}};
    endcase
  end

  // Next-state selection; every non-idle state advances when its duration expires.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_LEAD;
        else          state_nxt_s = ST_IDLE;
      end
      ST_LEAD: begin
        if (end_s) state_nxt_s = rpt_r ? ST_RSPACE : ST_SPACE;
        else       state_nxt_s = ST_LEAD;
      end
      ST_SPACE: begin
        if (end_s) state_nxt_s = ST_BIT_MARK;
        else       state_nxt_s = ST_SPACE;
      end
      ST_BIT_MARK: begin
        if (end_s) state_nxt_s = ST_BIT_SPACE;
        else       state_nxt_s = ST_BIT_MARK;
      end
      ST_BIT_SPACE: begin
        if (end_s) state_nxt_s = (bit_idx_r == LAST_BIT) ? ST_STOP : ST_BIT_MARK;
        else       state_nxt_s = ST_BIT_SPACE;
      end
      ST_RSPACE: begin
        if (end_s) state_nxt_s = ST_STOP;
        else       state_nxt_s = ST_RSPACE;
      end
      ST_STOP: begin
        if (end_s) state_nxt_s = ST_GAP;
        else       state_nxt_s = ST_STOP;
      end
      ST_GAP: begin
        if (end_s) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, microsecond counter, frame shift register and bit index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      us_r      <= {US_W{1'b0}};
      shift_r   <= 32'd0;
      bit_idx_r <= 5'd0;
      rpt_r     <= 1'b0;
      ent_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ent_r   <= clr_s;
      if (clr_s) begin
        us_r <= {US_W{1'b0}};
      end else if (tick_s && (state_r != ST_IDLE)) begin
        us_r <= us_r + US_W'(1);
      end
      if (accept_s) begin
        // send_en wins over a simultaneous repeat request.
        shift_r <= nec_frame(addr, data);
        rpt_r   <= !send_en;
      end else if ((state_r == ST_BIT_SPACE) && end_s) begin
        shift_r   <= {1'b0, shift_r[31:1]};
        bit_idx_r <= bit_idx_r + 5'd1;
      end else if ((state_r == ST_SPACE) && end_s) begin
        bit_idx_r <= 5'd0;
      end
    end
  end

  // Registered outputs; the line follows the state one clock later, done marks the stop-mark rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      remote_out_r <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      remote_out_r <= !nec_is_mark(state_r);
      busy_r       <= accept_s || (state_r != ST_IDLE);
      done_r       <= ent_r && (state_r == ST_GAP);
    end
  end

  assign remote_out = remote_out_r;
  assign busy       = busy_r;
  assign done       = done_r;

`ifdef IR_CARRIER_EN
  localparam int CAR_HALF = CLK_FREQ / (2 * CARRIER_HZ);
  localparam int CAR_W    = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CAR_HALF - 1);

  logic [CAR_W-1:0] car_cnt_r;
  logic             carrier_r;

  // Carrier square wave during marks; phase restarts high at every mark start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      car_cnt_r <= {CAR_W{1'b0}};
      carrier_r <= 1'b0;
    end else if (!nec_is_mark(state_r)) begin
      car_cnt_r <= {CAR_W{1'b0}};
      carrier_r <= 1'b0;
    end else if (remote_out_r) begin
      car_cnt_r <= {CAR_W{1'b0}};
      carrier_r <= 1'b1;
    end else if (car_cnt_r == CAR_LAST) begin
      car_cnt_r <= {CAR_W{1'b0}};
      carrier_r <= !carrier_r;
    end else begin
      car_cnt_r <= car_cnt_r + CAR_W'(1);
      carrier_r <= carrier_r;
    end
  end

  assign carrier_out = carrier_r;
`endif

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx with scaled-down timings (2 MHz clock,
// short durations) so that complete frames and gaps fit in a short run.
module tb_ir_nec_tx;

  localparam int CLK_FREQ = 2_000_000;
  localparam int D        = 2;
  localparam int LEAD     = 90;
  localparam int SPC      = 45;
  localparam int RPT      = 22;
  localparam int BITU     = 6;
  localparam int ONE      = 17;
  localparam int GAP      = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       send_en = 1'b0;
  logic       repeat_req = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic       busy;
  logic       done;
  logic       remote_out;
`ifdef IR_CARRIER_EN
  logic       carrier_out;
`endif

  always #5 clk = ~clk;

  ir_nec_tx #(
    .CLK_FREQ(CLK_FREQ), .LEAD_US(LEAD), .SPACE_US(SPC), .RPT_SPACE_US(RPT),
    .BIT_US(BITU), .ONE_US(ONE), .GAP_US(GAP)
`ifdef IR_CARRIER_EN
    , .CARRIER_HZ(100_000)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .send_en(send_en), .repeat_req(repeat_req),
    .addr(addr), .data(data), .busy(busy), .done(done), .remote_out(remote_out)
`ifdef IR_CARRIER_EN
    , .carrier_out(carrier_out)
`endif
  );

  typedef struct {
    logic lvl;
    int   len;
    bit   last;
  } seg_t;

  seg_t exp_q[$];
  seg_t e;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  bit   abort = 1'b1;
  bit   in_frame = 1'b0;
  logic prev = 1'b1;
  int   run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] d);
    logic [31:0] v;
    v = {~d, d, ~a, a};
    exp_q.push_back('{1'b0, LEAD * D, 1'b0});
    exp_q.push_back('{1'b1, SPC * D, 1'b0});
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{1'b0, BITU * D, 1'b0});
      exp_q.push_back('{1'b1, (v[i] ? ONE : BITU) * D, 1'b0});
    end
    exp_q.push_back('{1'b0, BITU * D, 1'b1});
  endtask

  task automatic push_repeat();
    exp_q.push_back('{1'b0, LEAD * D, 1'b0});
    exp_q.push_back('{1'b1, RPT * D, 1'b0});
    exp_q.push_back('{1'b0, BITU * D, 1'b1});
  endtask

  function automatic int bit10_offset(input logic [7:0] a, input logic [7:0] d);
    logic [31:0] v;
    int o;
    v = {~d, d, ~a, a};
    o = (LEAD + SPC) * D;
    for (int i = 0; i < 10; i++) o += (BITU + (v[i] ? ONE : BITU)) * D;
    o += BITU * D;
    return o;
  endfunction

  // Request pulse from a negedge; checks the accept-edge and first-low timing.
  task automatic request(input string tag, input logic s, input logic r,
                         input logic [7:0] a, input logic [7:0] d);
    addr = a; data = d; send_en = s; repeat_req = r;
    @(posedge clk); #1;
    send_en = 1'b0; repeat_req = 1'b0;
    chk({tag, "_acc_busy"}, busy, 1'b1);
    chk({tag, "_acc_line_hi"}, remote_out, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_acc_line_lo"}, remote_out, 1'b0);
  endtask

  // Waits for done, then checks its alignment, width and the gap before busy drops.
  task automatic finish_frame(input string tag);
    bit seen;
    int cnt;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({tag, "_rise_at_done"}, remote_out, 1'b1);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        if (cnt == 1) chk({tag, "_done_width"}, done, 1'b0);
      end while (busy === 1'b1 && cnt < 1000);
      chk({tag, "_gap_after_done"}, cnt, GAP * D);
    end
  endtask

  // Line monitor: measures each level run and compares it with the scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
`ifdef IR_CARRIER_EN
    if (remote_out === 1'b1) chk("carrier_idle", carrier_out, 1'b0);
`endif
    if (abort || rstn !== 1'b1) begin
      in_frame = 1'b0;
      prev = remote_out;
      run = 0;
    end else if (remote_out === prev) begin
      run++;
    end else begin
      if (prev === 1'b1 && !in_frame) begin
        in_frame = 1'b1;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_seg_len", run, 0);
      end else begin
        e = exp_q.pop_front();
        chk("seg_level", prev, e.lvl);
        chk("seg_len", run, e.len);
        in_frame = !e.last;
      end
      prev = remote_out;
      run = 1;
    end
  end

  initial begin
    int d0;
    int lows;
    int off;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_line", remote_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);

    // Full data frame; inputs change after acceptance
    d0 = done_cnt;
    push_frame(8'h5A, 8'h45);
    request("f1", 1'b1, 1'b0, 8'h5A, 8'h45);
    addr = 8'hFF; data = 8'h00;
    finish_frame("f1");
    chk("f1_done_count", done_cnt - d0, 1);

    // Repeat code
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    push_repeat();
    request("rp", 1'b0, 1'b1, 8'h11, 8'h22);
    finish_frame("rp");
    chk("rp_done_count", done_cnt - d0, 1);

    // Simultaneous send and repeat: only the data frame goes out
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    push_frame(8'h00, 8'hFF);
    request("sim", 1'b1, 1'b1, 8'h00, 8'hFF);
    finish_frame("sim");
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (remote_out !== 1'b1) lows++;
    end
    chk("sim_no_repeat_lows", lows, 0);
    chk("sim_queue_empty", exp_q.size(), 0);
    chk("sim_done_count", done_cnt - d0, 1);

    // Request during the leader is ignored
    d0 = done_cnt;
    push_frame(8'hA7, 8'h19);
    request("ld", 1'b1, 1'b0, 8'hA7, 8'h19);
    repeat (40) @(negedge clk);
    request_ignored: begin
      addr = 8'hC3; data = 8'h3C; send_en = 1'b1;
      @(posedge clk); #1;
      send_en = 1'b0;
      chk("ld_busy_hold", busy, 1'b1);
    end
    finish_frame("ld");
    repeat (300) @(negedge clk);
    chk("ld_done_count", done_cnt - d0, 1);
    chk("ld_queue_empty", exp_q.size(), 0);

    // Reset in the space of bit 10, then a clean frame
    off = bit10_offset(8'h5A, 8'h45);
    push_frame(8'h5A, 8'h45);
    request("rs", 1'b1, 1'b0, 8'h5A, 8'h45);
    @(negedge clk);
    repeat (off + 2) @(negedge clk);
    chk("rs_in_space", remote_out, 1'b1);
    abort = 1'b1;
    exp_q.delete();
    rstn = 1'b0;
    #1;
    chk("rs_line_in_reset", remote_out, 1'b1);
    chk("rs_busy_in_reset", busy, 1'b0);
    #99;
    rstn = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (remote_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("rs_quiet_after", lows, 0);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    push_frame(8'h5A, 8'h45);
    request("rs2", 1'b1, 1'b0, 8'h5A, 8'h45);
    finish_frame("rs2");
    chk("rs2_done_count", done_cnt - d0, 1);

    repeat (20) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
- NEC-protocol IR frame generator; sits directly upstream of remote_rcv.
- remote_out uses the same demodulated-level format that remote_rcv accepts on remote_in: idle 1, mark 0.
- Sends a full frame (addr, ~addr, data, ~data) or a repeat code on request.
- Used for loopback self-test of the receiver and as a transmitter for IR LED drivers.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; must be an integer multiple of 1_000_000.
- LEAD_US, 9000, leader mark length in µs.
- SPACE_US, 4500, data-frame leader space in µs.
- RPT_SPACE_US, 2250, repeat-frame leader space in µs.
- BIT_US, 560, bit mark length, logic-0 space length and stop mark length, in µs.
- ONE_US, 1690, logic-1 space length in µs.
- GAP_US, 40000, minimum idle-high time after any frame before a new request is accepted, in µs.
- CARRIER_HZ, 38000, carrier frequency; used only with IR_CARRIER_EN.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- send_en  input  1  single-cycle request to send a full data frame.
- repeat_req  input  1  single-cycle request to send a repeat code.
- addr  input  8  address code; sampled when send_en is accepted.
- data  input  8  command code; sampled when send_en is accepted.
- busy  output  1  high from request acceptance to the end of GAP.
- done  output  1  one-cycle pulse when the stop mark ends.
- remote_out  output  1  IR waveform; idle 1, mark 0.
- carrier_out  output  1  present only with IR_CARRIER_EN.

Behaviour:
- Reset (asynchronous, rstn=0): remote_out=1, busy=0, done=0, carrier_out=0, FSM in IDLE, all counters cleared.
- Reset asserted mid-frame forces remote_out high immediately. No partial-frame resume after release.
- Timebase: a 1 µs strobe is generated by dividing clk by CLK_FREQ/1_000_000. All durations are counted in whole strobes. The µs counter restarts at 0 on each state entry.
- All outputs are registered.

State machine:
- IDLE → LEAD on an accepted request. Request acceptance occurs only in IDLE with busy=0.
- Accept edge N: busy=1 at edge N, remote_out=0 at edge N+1. {addr, ~addr, data, ~data} is latched into a 32-bit shift register, LSB of addr first.
- LEAD: remote_out=0 for LEAD_US, then go to SPACE (full frame) or RSPACE (repeat).
- SPACE: remote_out=1 for SPACE_US → BIT_MARK, bit index=0.
- BIT_MARK: remote_out=0 for BIT_US → BIT_SPACE.
- BIT_SPACE: remote_out=1 for ONE_US if the current bit is 1, else BIT_US.
  - Then shift and increment the index.
  - Index 31 done → STOP; otherwise → BIT_MARK.
- RSPACE: remote_out=1 for RPT_SPACE_US → STOP.
- STOP: remote_out=0 for BIT_US, then remote_out=1, done=1 for one cycle → GAP.
- GAP: remote_out=1, busy=1 for GAP_US → IDLE, busy=0.

Request rules:
- send_en and repeat_req in the same IDLE cycle: send_en wins; repeat_req is discarded.
- Requests while busy=1 are ignored, not queued.
- addr/data changes after acceptance have no effect on the frame in progress.

Width rules:
- The µs counter is wide enough for max(GAP_US, LEAD_US); 16 bits at defaults.
- Prescaler width is $clog2(CLK_FREQ/1_000_000).

Optional Feature:
- Macro: IR_CARRIER_EN.
- Defined:
  - Port carrier_out exists.
  - carrier_out = 50% square wave at CARRIER_HZ (half period CLK_FREQ/(2*CARRIER_HZ) clocks, integer-truncated) while remote_out=0; otherwise 0.
  - The carrier phase counter restarts at each mark start, so every mark begins with a high half-cycle.
- Undefined: port and logic absent; remote_out behaviour is identical in both builds.

Decomposition:
- Package ir_nec_pkg:
  - FSM state enum (IDLE, LEAD, SPACE, RSPACE, BIT_MARK, BIT_SPACE, STOP, GAP).
  - NEC frame bit count (32).
  - Default timing constants in µs.
- Sub-module ir_us_tick: parameterised by CLK_FREQ, outputs a one-cycle 1 µs strobe. Counter restarts on rstn.

Test Plan:
- Data frame, addr=8'h5A, data=8'h45, 50 MHz clock:
  - remote_out: 9000 µs low, 4500 µs high, then 32 bits LSB-first (16 ones, 16 zeros), then 560 µs stop low.
  - Total 67,980 µs from first low to final rise.
  - done pulses once; busy falls 40,000 µs after done.
  - Loopback into remote_rcv gives data_en with data=8'h45.
- Repeat frame:
  - repeat_req → 9000 µs low, 2250 µs high, 560 µs low, total 11,810 µs.
  - remote_rcv asserts repeat_en.
- Simultaneous send_en and repeat_req in IDLE: a full data frame is sent; no repeat code follows.
- send_en pulsed at 1000 µs into LEAD with different addr/data: ignored; frame bits match the first request; exactly one done.
- rstn low for 100 ns during BIT_SPACE of bit 10:
  - remote_out=1 and busy=0 within the reset window.
  - After release, no activity until the next send_en, which then produces a clean full frame.
- With IR_CARRIER_EN: during the leader, carrier_out toggles every 657 clocks (38 kHz from 50 MHz). carrier_out=0 whenever remote_out=1.
